rs_station: RTL and testbench

- Parametrised reservation station between the decode/ROB dispatch stage and one ALU.
- Holds up to DEPTH renamed instructions and captures operands from NUM_CDB result buses by ROB tag.
- Issues one ready instruction per cycle over a valid/ready handshake, and supports full flush on branch mispredict.
- Replaces the fixed 16-entry station: explicit tag fields instead of value-encoded tags, multi-CDB wakeup, backpressure, flush and occupancy count.

---
 rtl/rs_station_pkg.sv | 20 ++
 rtl/rs_station_select.sv | 24 ++
 rtl/rs_station.sv | 217 +++++++++++++++++++++
 tb/tb_rs_station.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_station_pkg.sv
// Default reservation-station sizing and the internal ALU opcode encodings.
// The entry record itself is declared in rs_station so that it tracks the module parameters.
package rs_station_pkg;

    localparam int unsigned RS_DEPTH   = 16;
    localparam int unsigned RS_DATA_W  = 32;
    localparam int unsigned RS_TAG_W   = 4;
    localparam int unsigned RS_OP_W    = 6;
    localparam int unsigned RS_NUM_CDB = 2;

    typedef enum logic [RS_OP_W-1:0] {
        ALU_ADD = 6'd0,
        ALU_SUB = 6'd1,
        ALU_AND = 6'd2,
        ALU_OR  = 6'd3,
        ALU_XOR = 6'd4,
        ALU_SLT = 6'd5
    } alu_op_e;

endpackage

// File: rtl/rs_station_select.sv
// rs_select: combinational DEPTH-wide one-hot picker. It grants the lowest-index request.
// It also grants the oldest request when older[i][j] marks entry j as older than entry i.
module rs_select #(
    parameter int unsigned DEPTH = 16
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    // With older tied to zero every request is a candidate, so this reduces to lowest-index.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && req[i] && ((older[i] & req) == '0)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station with multi-CDB wakeup, dispatch bypass, issue handshake and flush.
// Define RS_AGE_SELECT_EN to issue the oldest eligible entry instead of the lowest-index one.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int unsigned DEPTH   = RS_DEPTH,
    parameter int unsigned DATA_W  = RS_DATA_W,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned OP_W    = RS_OP_W,
    parameter int unsigned NUM_CDB = RS_NUM_CDB,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [OP_W-1:0]             disp_op,
    input  logic [TAG_W-1:0]            disp_tag,
    input  logic [DATA_W-1:0]           disp_v1,
    input  logic [DATA_W-1:0]           disp_v2,
    input  logic [TAG_W-1:0]            disp_q1,
    input  logic [TAG_W-1:0]            disp_q2,
    input  logic                        disp_r1,
    input  logic                        disp_r2,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [OP_W-1:0]             iss_op,
    output logic [DATA_W-1:0]           iss_v1,
    output logic [DATA_W-1:0]           iss_v2,
    output logic [TAG_W-1:0]            iss_tag,
    output logic [CNT_W-1:0]            count
);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  q1;
        logic              r1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  q2;
        logic              r2;
    } entry_t;

    entry_t                      ent      [DEPTH];
    entry_t                      ent_next [DEPTH];
    entry_t                      new_ent;
    logic [DEPTH-1:0]            eligible, free_vec, pick_grant, free_grant;
    logic                        pick_found, free_found, accept, advance, take;
    logic [DEPTH-1:0][DEPTH-1:0] older;
    logic [DATA_W:0]             h1, h2;
    logic [OP_W-1:0]             pick_op;
    logic [TAG_W-1:0]            pick_tag;
    logic [DATA_W-1:0]           pick_v1, pick_v2;

    // Returns {hit, data}; the lowest-numbered matching bus wins.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]          q,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] hit;
        hit = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (!hit[DATA_W] && vld[k] && (tags[k*TAG_W +: TAG_W] == q))
                hit = {1'b1, data[k*DATA_W +: DATA_W]};
        end
        return hit;
    endfunction

    assign disp_ready = rdy && !flush && (count < CNT_W'(DEPTH));
    assign accept     = disp_valid && disp_ready && free_found;
    assign advance    = rdy && !flush && (!iss_valid || iss_ready);
    assign take       = advance && pick_found;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i] = ent[i].valid && ent[i].r1 && ent[i].r2;
            free_vec[i] = !ent[i].valid;
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_pick (
        .req   (eligible),
        .older (older),
        .grant (pick_grant),
        .found (pick_found)
    );

    rs_select #(.DEPTH(DEPTH)) u_free (
        .req   (free_vec),
        .older ('0),
        .grant (free_grant),
        .found (free_found)
    );

    always_comb begin
        pick_op  = '0;
        pick_tag = '0;
        pick_v1  = '0;
        pick_v2  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pick_grant[i]) begin
                pick_op  = ent[i].op;
                pick_tag = ent[i].tag;
                pick_v1  = ent[i].v1;
                pick_v2  = ent[i].v2;
            end
        end
    end

    // Dispatch bypass: an operand arriving on a CDB in the dispatch cycle is stored ready.
    always_comb begin
        h1            = snoop(disp_q1, cdb_valid, cdb_tag, cdb_data);
        h2            = snoop(disp_q2, cdb_valid, cdb_tag, cdb_data);
        new_ent.valid = 1'b1;
        new_ent.op    = disp_op;
        new_ent.tag   = disp_tag;
        new_ent.q1    = disp_q1;
        new_ent.q2    = disp_q2;
        new_ent.r1    = disp_r1 || h1[DATA_W];
        new_ent.r2    = disp_r2 || h2[DATA_W];
        new_ent.v1    = disp_r1 ? disp_v1 : h1[DATA_W-1:0];
        new_ent.v2    = disp_r2 ? disp_v2 : h2[DATA_W-1:0];
    end

    always_comb begin
        logic [DATA_W:0] w1, w2;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_next[i] = ent[i];
            w1 = snoop(ent[i].q1, cdb_valid, cdb_tag, cdb_data);
            w2 = snoop(ent[i].q2, cdb_valid, cdb_tag, cdb_data);
            if (ent[i].valid && !ent[i].r1 && w1[DATA_W]) begin
                ent_next[i].r1 = 1'b1;
                ent_next[i].v1 = w1[DATA_W-1:0];
            end
            if (ent[i].valid && !ent[i].r2 && w2[DATA_W]) begin
                ent_next[i].r2 = 1'b1;
                ent_next[i].v2 = w2[DATA_W-1:0];
            end
            if (take && pick_grant[i])
                ent_next[i].valid = 1'b0;
            if (accept && free_grant[i])
                ent_next[i] = new_ent;
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] age, age_next;

    // age[i][j] set means entry j is older than entry i; a new entry is younger than everyone.
    always_comb begin
        age_next = age;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (take && pick_grant[i]) begin
                age_next[i] = '0;
                for (int unsigned j = 0; j < DEPTH; j++) age_next[j][i] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (accept && free_grant[i]) begin
                age_next[i] = '1;
                for (int unsigned j = 0; j < DEPTH; j++) age_next[j][i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            age <= '0;
        else if (rdy)
            age <= flush ? '0 : age_next;
    end

    assign older = age;
`else
    assign older = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
            count     <= '0;
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_v1    <= '0;
            iss_v2    <= '0;
            iss_tag   <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
                count     <= '0;
                iss_valid <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= ent_next[i];
                count <= count + CNT_W'(accept) - CNT_W'(take);
                if (advance) begin
                    iss_valid <= pick_found;
                    if (pick_found) begin
                        iss_op  <= pick_op;
                        iss_v1  <= pick_v1;
                        iss_v2  <= pick_v2;
                        iss_tag <= pick_tag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a slot-array reference model.
module tb_rs_station;
    import rs_station_pkg::*;

    localparam int DEPTH = 16;
`ifdef RS_AGE_SELECT_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, flush, disp_valid, disp_ready, disp_r1, disp_r2;
    logic        iss_valid, iss_ready;
    logic [5:0]  disp_op, iss_op;
    logic [3:0]  disp_tag, disp_q1, disp_q2, iss_tag;
    logic [31:0] disp_v1, disp_v2, iss_v1, iss_v2;
    logic [1:0]  cdb_valid;
    logic [3:0]  ct [2];
    logic [31:0] cd [2];
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic [4:0]  count;

    assign cdb_tag  = {ct[1], ct[0]};
    assign cdb_data = {cd[1], cd[0]};

    always #5 clk = ~clk;

    rs_station #(
        .DEPTH(16), .DATA_W(32), .TAG_W(4), .OP_W(6), .NUM_CDB(2), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_tag(disp_tag),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_r1(disp_r1), .disp_r2(disp_r2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_tag(iss_tag), .count(count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        logic [5:0]  op;
        logic [3:0]  tag;
        logic [31:0] v1, v2;
        logic [3:0]  q1, q2;
        bit          r1, r2;
        int          seq;
    } slot_t;

    slot_t       m [DEPTH];
    int          m_cnt, seq_ctr;
    bit          m_iv;
    logic [5:0]  m_op;
    logic [3:0]  m_tag;
    logic [31:0] m_v1, m_v2;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
        m_cnt = 0; m_iv = 1'b0; seq_ctr = 0;
        m_op = '0; m_tag = '0; m_v1 = '0; m_v2 = '0;
    endtask

    function automatic bit bus_hit(input logic [3:0] q, output logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && ct[k] == q) begin
                d = cd[k];
                return 1'b1;
            end
        end
        d = '0;
        return 1'b0;
    endfunction

    task automatic model_step();
        slot_t       nxt [DEPTH];
        int          pick, fr;
        bit          acc;
        logic [31:0] d;
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
            m_cnt = 0; m_iv = 1'b0;
            return;
        end
        nxt  = m;
        acc  = disp_valid && (m_cnt < DEPTH);
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].valid && m[i].r1 && m[i].r2) begin
                if (pick < 0) pick = i;
                else if (AGE && m[i].seq < m[pick].seq) pick = i;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].valid && !m[i].r1 && bus_hit(m[i].q1, d)) begin nxt[i].r1 = 1'b1; nxt[i].v1 = d; end
            if (m[i].valid && !m[i].r2 && bus_hit(m[i].q2, d)) begin nxt[i].r2 = 1'b1; nxt[i].v2 = d; end
        end
        if (!m_iv || iss_ready) begin
            if (pick >= 0) begin
                m_iv = 1'b1; m_op = m[pick].op; m_tag = m[pick].tag;
                m_v1 = m[pick].v1; m_v2 = m[pick].v2;
                nxt[pick].valid = 1'b0;
                m_cnt--;
            end else m_iv = 1'b0;
        end
        if (acc) begin
            fr = -1;
            for (int i = 0; i < DEPTH; i++) if (fr < 0 && !m[i].valid) fr = i;
            nxt[fr].valid = 1'b1; nxt[fr].op = disp_op; nxt[fr].tag = disp_tag;
            nxt[fr].q1 = disp_q1; nxt[fr].q2 = disp_q2;
            nxt[fr].r1 = disp_r1; nxt[fr].v1 = disp_v1;
            nxt[fr].r2 = disp_r2; nxt[fr].v2 = disp_v2;
            if (!disp_r1 && bus_hit(disp_q1, d)) begin nxt[fr].r1 = 1'b1; nxt[fr].v1 = d; end
            if (!disp_r2 && bus_hit(disp_q2, d)) begin nxt[fr].r2 = 1'b1; nxt[fr].v2 = d; end
            nxt[fr].seq = seq_ctr++;
            m_cnt++;
        end
        m = nxt;
    endtask

    // One clock: check disp_ready, advance model, compare registered outputs after the edge.
    task automatic tick();
        #1;
        check("m_disp_ready", 64'(disp_ready), 64'(rdy && !flush && (m_cnt < DEPTH)));
        model_step();
        @(posedge clk);
        #1;
        check("m_count", 64'(count), 64'(m_cnt));
        check("m_iss_valid", 64'(iss_valid), 64'(m_iv));
        if (m_iv) begin
            check("m_iss_op", 64'(iss_op), 64'(m_op));
            check("m_iss_tag", 64'(iss_tag), 64'(m_tag));
            check("m_iss_v1", 64'(iss_v1), 64'(m_v1));
            check("m_iss_v2", 64'(iss_v2), 64'(m_v2));
        end
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_tag = '0;
        disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0; disp_r1 = 1'b0; disp_r2 = 1'b0;
        cdb_valid = '0; ct[0] = '0; ct[1] = '0; cd[0] = '0; cd[1] = '0; iss_ready = 1'b1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] tag,
                        input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] q2);
        disp_valid = 1'b1; disp_op = op; disp_tag = tag;
        disp_r1 = r1; disp_v1 = v1; disp_q1 = q1;
        disp_r2 = r2; disp_v2 = v2; disp_q2 = q2;
    endtask

    task automatic bus(input int k, input logic [3:0] tag, input logic [31:0] data);
        cdb_valid[k] = 1'b1; ct[k] = tag; cd[k] = data;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          dv;
        logic [3:0]  tag;
        bit          r1;
        logic [31:0] v1;
        logic [3:0]  q1;
        bit          r2;
        logic [31:0] v2;
        logic [3:0]  q2;
        int          cbus;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        bit          e_iv;
        logic [3:0]  e_tag;
        logic [31:0] e_v1, e_v2;
        int          e_cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // simple ready dispatch, CDB wakeup on bus 1, dispatch-cycle bypass on bus 0
        vecs[0] = '{1'b1, 4'd3, 1'b1, 32'd5,  4'd0, 1'b1, 32'd7,  4'd0, 0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1};
        vecs[1] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b1, 4'd3, 32'd5, 32'd7, 0};
        vecs[2] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0};
        vecs[3] = '{1'b1, 4'd1, 1'b0, 32'd0,  4'd9, 1'b1, 32'd2,  4'd0, -1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1};
        vecs[4] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, 1, 4'd9, 32'h1234, 1'b0, 4'd0, 32'd0, 32'd0, 1};
        vecs[5] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b1, 4'd1, 32'h1234, 32'd2, 0};
        vecs[6] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0};
        vecs[7] = '{1'b1, 4'd2, 1'b1, 32'h11, 4'd0, 1'b0, 32'd0,  4'd4, 0, 4'd4, 32'hAA, 1'b0, 4'd0, 32'd0, 32'd0, 1};
        vecs[8] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b1, 4'd2, 32'h11, 32'hAA, 0};
        vecs[9] = '{1'b0, 4'd0, 1'b0, 32'd0,  4'd0, 1'b0, 32'd0,  4'd0, -1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0};
        // vecs[0] has cbus 0 with cdb valid unset below only when dv and cbus>=0 and tag matches nothing
        vecs[0].cbus = -1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_iss_op", 64'(iss_op), 64'd0);
        check("rst_iss_v1", 64'(iss_v1), 64'd0);
        check("rst_iss_v2", 64'(iss_v2), 64'd0);
        check("rst_iss_tag", 64'(iss_tag), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            idle();
            if (vecs[i].dv)
                disp(ALU_ADD, vecs[i].tag, vecs[i].r1, vecs[i].v1, vecs[i].q1,
                     vecs[i].r2, vecs[i].v2, vecs[i].q2);
            if (vecs[i].cbus >= 0) bus(vecs[i].cbus, vecs[i].ctag, vecs[i].cdata);
            tick();
            check($sformatf("vec%0d_iss_valid", i), 64'(iss_valid), 64'(vecs[i].e_iv));
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_iv) begin
                check($sformatf("vec%0d_tag", i), 64'(iss_tag), 64'(vecs[i].e_tag));
                check($sformatf("vec%0d_v1", i), 64'(iss_v1), 64'(vecs[i].e_v1));
                check($sformatf("vec%0d_v2", i), 64'(iss_v2), 64'(vecs[i].e_v2));
                check($sformatf("vec%0d_op", i), 64'(iss_op), 64'(ALU_ADD));
            end
        end

        // fill all entries with waiting operands; entry 0 waits on tag 14, the rest on 15
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            disp(ALU_SUB, 4'(i), 1'b0, 32'd0, (i == 0) ? 4'd14 : 4'd15, 1'b1, 32'(i), 4'd0);
            tick();
        end
        check("full_count", 64'(count), 64'd16);
        idle();
        disp(ALU_ADD, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        #1;
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        tick();
        check("full_reject_count", 64'(count), 64'd16);
        idle();
        iss_ready = 1'b0;
        bus(0, 4'd14, 32'hBEEF);
        tick();
        idle();
        iss_ready = 1'b0;
        tick();
        check("stall_first_valid", 64'(iss_valid), 64'd1);
        check("stall_first_count", 64'(count), 64'd15);
        for (int c = 0; c < 5; c++) begin
            idle();
            iss_ready = 1'b0;
            if (c == 1) bus(1, 4'd15, 32'hCAFE);
            tick();
            check($sformatf("stall%0d_valid", c), 64'(iss_valid), 64'd1);
            check($sformatf("stall%0d_tag", c), 64'(iss_tag), 64'd0);
            check($sformatf("stall%0d_v1", c), 64'(iss_v1), 64'hBEEF);
            check($sformatf("stall%0d_op", c), 64'(iss_op), 64'(ALU_SUB));
        end
        idle();
        flush = 1'b1;
        disp(ALU_ADD, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        tick();
        check("flush_full_count", 64'(count), 64'd0);
        check("flush_full_valid", 64'(iss_valid), 64'd0);

        // six waiting entries plus a held issue, then flush with a dispatch attempt
        for (int i = 0; i < 7; i++) begin
            idle();
            iss_ready = 1'b0;
            disp(ALU_XOR, 4'(i + 1), (i == 0), 32'd3, 4'd13, 1'b1, 32'd4, 4'd0);
            tick();
        end
        check("pre_flush_count", 64'(count), 64'd6);
        check("pre_flush_valid", 64'(iss_valid), 64'd1);
        idle();
        iss_ready = 1'b0;
        flush = 1'b1;
        disp(ALU_ADD, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(iss_valid), 64'd0);
        idle();
        tick();
        check("flush_drop_count", 64'(count), 64'd0);

        // rdy low freezes dispatch
        idle();
        rdy = 1'b0;
        disp(ALU_OR, 4'd7, 1'b1, 32'd8, 4'd0, 1'b1, 32'd9, 4'd0);
        tick();
        check("frozen_count", 64'(count), 64'd0);
        idle();
        disp(ALU_OR, 4'd7, 1'b1, 32'd8, 4'd0, 1'b1, 32'd9, 4'd0);
        tick();
        check("unfrozen_count", 64'(count), 64'd1);
        idle();
        rdy = 1'b0;
        tick();
        check("frozen_no_issue", 64'(iss_valid), 64'd0);
        idle();
        tick();
        check("thaw_issue_tag", 64'(iss_tag), 64'd7);

        // selection order: A (entry 2) dispatched before B (entry 0)
        idle(); disp(ALU_ADD, 4'd5, 1'b0, 32'd0, 4'd11, 1'b1, 32'd0, 4'd0); tick();
        idle(); disp(ALU_ADD, 4'd6, 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0); tick();
        idle(); disp(ALU_ADD, 4'd7, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0); tick();
        idle(); bus(0, 4'd11, 32'd1); tick();
        idle(); tick();
        check("order_x0_tag", 64'(iss_tag), 64'd5);
        idle(); disp(ALU_ADD, 4'd8, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0); tick();
        idle(); bus(0, 4'd12, 32'h55); tick();
        idle(); tick();
        check("order_first_tag", 64'(iss_tag), AGE ? 64'd7 : 64'd8);
        idle(); tick();
        check("order_second_tag", 64'(iss_tag), AGE ? 64'd8 : 64'd7);
        check("order_v1", 64'(iss_v1), 64'h55);
        idle(); flush = 1'b1; tick();

        // randomized traffic against the model, with an async reset part way through
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy   = ($urandom % 16) != 0;
            flush = ($urandom % 80) == 0;
            if (($urandom % 10) < 6)
                disp(6'($urandom_range(0, 5)), 4'($urandom), 1'($urandom), $urandom, 4'($urandom),
                     1'($urandom), $urandom, 4'($urandom));
            ct[0] = 4'($urandom);
            ct[1] = 4'(ct[0] + 4'd1 + 4'($urandom_range(0, 14)));
            cd[0] = $urandom;
            cd[1] = $urandom;
            cdb_valid = {($urandom % 10) < 4, ($urandom % 10) < 4};
            iss_ready = ($urandom % 10) < 7;
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                check("async_rst_count", 64'(count), 64'd0);
                check("async_rst_valid", 64'(iss_valid), 64'd0);
                check("async_rst_v1", 64'(iss_v1), 64'd0);
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
